serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial N-bit adder controller. It time-multiplexes one instance of the team's 1-bit full_adder cell (A, B, Cin -> Sum, Cout) over WIDTH bit positions, LSB first. It latches operands on a start handshake, runs one bit per clock while holding the carry in a register, and presents the registered WIDTH-bit result with a one-cycle done pulse. Intended as the area-minimal arithmetic sequencer for the training datapath.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32
CNT_W, (WIDTH>1 ? $clog2(WIDTH) : 1), bit-index counter width; derived, do not override

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
A  input  WIDTH  operand A; sampled on accepted start
B  input  WIDTH  operand B; sampled on accepted start
Cin  input  1  carry-in; sampled on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse, result valid
Sum  output  WIDTH  registered result
Cout  output  1  registered final carry-out

Behaviour:
- Reset (rst_n low, async, any state): state=IDLE, busy=0, done=0, Sum=0, Cout=0, internal shift regs, carry reg and counter = 0.
- FSM states: IDLE, RUN, DONE. All outputs registered; no combinational input->output paths.
- IDLE: if start=1 at clock edge -> load opa<=A, opb<=B, carry<=Cin, sum_sr<=0, cnt<=0; go RUN. Otherwise stay; Sum/Cout hold last result.
- RUN, each edge: full_adder inputs = opa[0], opb[0], carry. opa, opb shift right by 1 (zero fill); sum_sr shifts right with the full_adder Sum bit entering at MSB; carry<=full_adder Cout; cnt<=cnt+1.
- RUN exit: on the edge where cnt==WIDTH-1 -> Sum<=final sum_sr value (including this bit), Cout<=full_adder Cout; go DONE.
- DONE: done=1 for exactly this one cycle; next edge -> IDLE unconditionally.
- busy=1 exactly in RUN (WIDTH cycles); done=1 exactly in DONE.
- Latency: start sampled at edge 0; busy high for edges 1..WIDTH; done high in the cycle after edge WIDTH; Sum/Cout valid from that cycle until the next result is written.
- Sum/Cout change only on the RUN->DONE transition (or reset). They never show partial results.
- start while RUN or DONE: ignored, not queued. start held high continuously: a new operation is accepted in IDLE, the cycle after done, i.e. one operation every WIDTH+2 cycles.
- A, B, Cin changes after the accepted start have no effect on the running operation.
- Arithmetic: {Cout, Sum} = A + B + Cin, modulo 2^(WIDTH+1); unsigned; no overflow flag.
- WIDTH=1: RUN lasts one cycle (cnt==0 is the terminal count).
- Reset mid-RUN or in DONE: operation aborted, no done pulse. After release, IDLE with Sum=0, Cout=0.
- Counter never exceeds WIDTH-1; no wrap within an operation.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> busy=0, done=0, Sum=8'h00, Cout=0 immediately, with no clock edge required.
- Basic add, WIDTH=8: A=8'h5A, B=8'h3C, Cin=0, start pulse -> busy for 8 cycles, done one cycle later (9 cycles after start edge), Sum=8'h96, Cout=0; Sum stays 8'h00 throughout RUN.
- Carry chain: A=8'hFF, B=8'h01, Cin=0 -> Sum=8'h00, Cout=1. Then A=8'hFF, B=8'hFF, Cin=1 -> Sum=8'hFF, Cout=1.
- Handshake: pulse start again at RUN cycle 3 and change A/B mid-RUN -> original result unchanged; exactly one done. With start held high -> done pulses every 10 cycles.
- Reset mid-op: start A=8'h12, B=8'h34, then assert rst_n=0 at RUN cycle 4 -> no done; after release Sum=0, Cout=0, state IDLE. A fresh start completes normally with Sum=8'h46.
- Exhaustive, WIDTH=1 build: all 8 {A, B, Cin} combinations -> {Cout, Sum} = A+B+Cin; done 2 cycles after each start edge.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder sequencing one full_adder cell LSB first
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = (WIDTH > 1 ? $clog2(WIDTH) : 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, sr_q, sr_d, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, cout_q, cout_d;
  logic fa_s, fa_c, last;
  logic [WIDTH:0] sr_cat;
  full_adder u_fa (.a(opa_q[0]), .b(opb_q[0]), .cin(carry_q), .s(fa_s), .cout(fa_c));
  assign sr_cat = {fa_s, sr_q};
  assign last   = cnt_q == CNT_W'(WIDTH - 1);
  assign busy   = state_q == RUN;
  assign done   = state_q == DONE;
  assign Sum    = sum_q;
  assign Cout   = cout_q;
  // next state: load on start, shift one bit per RUN cycle, publish result on terminal count
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: if (start) begin
        opa_d   = A;
        opb_d   = B;
        carry_d = Cin;
        sr_d    = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        sr_d    = sr_cat[WIDTH:1];
        carry_d = fa_c;
        cnt_d   = last ? cnt_q : cnt_q + 1'b1;
        if (last) begin
          sum_d   = sr_cat[WIDTH:1];
          cout_d  = fa_c;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed checks of the 8-bit and 1-bit serial adder builds
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic start, Cin, busy, done, Cout;
  logic [7:0] A, B, Sum;
  logic s1, a1, b1, c1, busy1, done1, sum1, cout1;
  int tests = 0;
  int fails = 0;
  logic [7:0] psum;
  int dcnt, last_d, ndone;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy), .done(done), .Sum(Sum), .Cout(Cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .A(a1), .B(b1), .Cin(c1),
    .busy(busy1), .done(done1), .Sum(sum1), .Cout(cout1)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [7:0] es, input logic ec);
    A = a; B = b; Cin = c; start = 1'b1;
    tick;
    start = 1'b0;
    chk("busy_first", busy, 1);
    for (int i = 1; i < 8; i++) begin
      tick;
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_sum_hold", Sum, psum);
    end
    tick;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("sum", Sum, es);
    chk("cout", Cout, ec);
    tick;
    chk("done_low", done, 0);
    psum = es;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    s1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    psum = 8'h00;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", Sum, 8'h00);
    chk("rst_cout", Cout, 0);
    #3 rst_n = 1'b1;
    tick;
    op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    op8(8'h80, 8'h80, 1'b1, 8'h01, 1'b1);
    // async reset mid-cycle with no edge
    #2 rst_n = 1'b0;
    #1;
    chk("async_sum", Sum, 8'h00);
    chk("async_cout", Cout, 0);
    chk("async_done", done, 0);
    #3 rst_n = 1'b1;
    psum = 8'h00;
    tick;
    // start re-pulsed and operands changed mid-run
    A = 8'h21; B = 8'h10; Cin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    ndone = 0;
    for (int i = 1; i < 16; i++) begin
      if (i == 3) begin start = 1'b1; A = 8'hFF; B = 8'hFF; Cin = 1'b1; end
      if (i == 4) start = 1'b0;
      tick;
      if (done) ndone++;
    end
    chk("hs_ndone", ndone, 1);
    chk("hs_sum", Sum, 8'h31);
    chk("hs_cout", Cout, 0);
    chk("hs_idle", busy, 0);
    // start held high: one result every 10 cycles
    A = 8'h01; B = 8'h01; Cin = 1'b0; start = 1'b1;
    ndone = 0; last_d = -1;
    for (int i = 0; i < 32; i++) begin
      tick;
      if (done) begin
        if (last_d >= 0) chk("held_period", i - last_d, 10);
        last_d = i;
        ndone++;
      end
    end
    chk("held_ndone", ndone >= 3, 1);
    chk("held_sum", Sum, 8'h02);
    start = 1'b0;
    repeat (12) tick;
    chk("held_idle", busy, 0);
    psum = 8'h02;
    // reset during RUN aborts the operation
    A = 8'h12; B = 8'h34; Cin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sum", Sum, 8'h00);
    #3 rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (done || busy) ndone++;
    end
    chk("mid_no_done", ndone, 0);
    chk("mid_sum", Sum, 8'h00);
    chk("mid_cout", Cout, 0);
    psum = 8'h00;
    op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
    // exhaustive 1-bit build
    for (int v = 0; v < 8; v++) begin
      a1 = v[2]; b1 = v[1]; c1 = v[0]; s1 = 1'b1;
      tick;
      s1 = 1'b0;
      chk("w1_busy", busy1, 1);
      chk("w1_early", done1, 0);
      tick;
      chk("w1_done", done1, 1);
      chk("w1_result", {cout1, sum1}, v[2] + v[1] + v[0]);
      tick;
      chk("w1_done_low", done1, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
